// File: rtl/priority_enc_pkg.sv
// Shared constants, width helper and result type for the priority encoder.
// Optional one-hot grant output is enabled by PRIORITY_ENC_ONEHOT_EN.
package priority_enc_pkg;

  localparam int DEF_WIDTH = 4;

  // An index bus is never narrower than one bit, so WIDTH=2 still gets OUT_W=1.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_OUT_W = clog2_min1(DEF_WIDTH);

  typedef struct packed {
    logic                 valid;
    logic [DEF_OUT_W-1:0] idx;
  } pe_res_t;

endpackage

// File: rtl/priority_enc_if.sv
// Request/result bundle: in (requests), out (winner index), valid,
// and out_onehot when PRIORITY_ENC_ONEHOT_EN is defined.
interface priority_enc_if
  import priority_enc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  localparam int OUT_W = clog2_min1(WIDTH);

  logic [WIDTH-1:0] in;
  logic [OUT_W-1:0] out;
  logic             valid;

`ifdef PRIORITY_ENC_ONEHOT_EN
  logic [WIDTH-1:0] out_onehot;

  modport master (
    output in,
    input  out,
    input  valid,
    input  out_onehot
  );

  modport slave (
    input  in,
    output out,
    output valid,
    output out_onehot
  );
`else
  modport master (
    output in,
    input  out,
    input  valid
  );

  modport slave (
    input  in,
    output out,
    output valid
  );
`endif

endinterface

// File: rtl/priority_enc_ffs.sv
// Combinational find-first-set from the MSB as a log2-depth merge tree.
// Ports: in (requests) -> idx (highest set bit), v (any set), onehot.
module priority_enc_ffs
  import priority_enc_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int OUT_W = clog2_min1(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] idx,
  output logic             v,
  output logic [WIDTH-1:0] onehot
);

  localparam int L = OUT_W;
  localparam int P = 1 << L;

  // Pad to a power of two; padded leaves are never set, so never win.
  logic [P-1:0] leaf;

  always_comb begin
    leaf = '0;
    leaf[WIDTH-1:0] = in;
  end

  for (genvar l = 0; l <= L; l++) begin : lvl
    localparam int N = P >> l;
    logic [N-1:0]            nv;
    logic [N-1:0][OUT_W-1:0] ni;

    if (l == 0) begin : g_leaf
      assign nv = leaf;
      for (genvar i = 0; i < N; i++) begin : g_i
        assign ni[i] = OUT_W'(i);
      end
    end else begin : g_merge
      // Upper child covers higher indices, so it wins whenever it is set.
      for (genvar j = 0; j < N; j++) begin : g_j
        assign nv[j] = lvl[l-1].nv[2*j+1] | lvl[l-1].nv[2*j];
        assign ni[j] = lvl[l-1].nv[2*j+1] ?
                       lvl[l-1].ni[2*j+1] :
                       lvl[l-1].ni[2*j];
      end
    end
  end

  // With no request every merge picks its lower child, ending at index 0.
  assign idx    = lvl[L].ni[0];
  assign v      = lvl[L].nv[0];
  assign onehot = v ? (WIDTH'(1) << idx) : '0;

endmodule

// File: rtl/priority_enc.sv
// Registered priority encoder: out/valid (and out_onehot with
// PRIORITY_ENC_ONEHOT_EN) follow bus.in one clock later; rst_n clears.
module priority_enc
  import priority_enc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  priority_enc_if.slave bus
);

  localparam int OUT_W = clog2_min1(WIDTH);

  logic [OUT_W-1:0] idx;
  logic             v;

`ifdef PRIORITY_ENC_ONEHOT_EN
  logic [WIDTH-1:0] oh;
`else
  logic [WIDTH-1:0] unused_oh;
`endif

  priority_enc_ffs #(
    .WIDTH (WIDTH)
  ) u_ffs (
    .in     (bus.in),
    .idx    (idx),
    .v      (v),
`ifdef PRIORITY_ENC_ONEHOT_EN
    .onehot (oh)
`else
    .onehot (unused_oh)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out   <= '0;
      bus.valid <= 1'b0;
    end else begin
      bus.out   <= idx;
      bus.valid <= v;
    end
  end

`ifdef PRIORITY_ENC_ONEHOT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_onehot <= '0;
    end else begin
      bus.out_onehot <= oh;
    end
  end
`endif

endmodule

// File: tb/tb_priority_enc.sv
// Self-checking bench for priority_enc at WIDTH 4, 8 and 5.
// One-hot checks are compiled in with PRIORITY_ENC_ONEHOT_EN.
module tb_priority_enc;

  logic clk;
  logic rst_n;

  priority_enc_if #(.WIDTH(4)) b4 ();
  priority_enc_if #(.WIDTH(8)) b8 ();
  priority_enc_if #(.WIDTH(5)) b5 ();

  priority_enc #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  priority_enc #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  priority_enc #(.WIDTH(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: scan from the top for the highest set bit.
  function automatic int top_bit(input logic [63:0] x);
    for (int i = 63; i >= 0; i--)
      if (x[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst_n && ($isunknown(b4.in) || $isunknown(b8.in)
                  || $isunknown(b5.in))) begin
      total++;
      $display("FAIL in_known: request vector has X/Z");
    end
  end

  typedef struct {
    logic [3:0] in;
    logic [1:0] out;
    logic       valid;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // single-hot sweep, each held two cycles (20 ns)
    vecs.push_back('{4'b0001, 2'd0, 1'b1, "hot0"});
    vecs.push_back('{4'b0001, 2'd0, 1'b1, "hot0_hold"});
    vecs.push_back('{4'b0010, 2'd1, 1'b1, "hot1"});
    vecs.push_back('{4'b0010, 2'd1, 1'b1, "hot1_hold"});
    vecs.push_back('{4'b0100, 2'd2, 1'b1, "hot2"});
    vecs.push_back('{4'b0100, 2'd2, 1'b1, "hot2_hold"});
    vecs.push_back('{4'b1000, 2'd3, 1'b1, "hot3"});
    vecs.push_back('{4'b1000, 2'd3, 1'b1, "hot3_hold"});
    // multi-hot priority
    vecs.push_back('{4'b1100, 2'd3, 1'b1, "multi_1100"});
    vecs.push_back('{4'b0110, 2'd2, 1'b1, "multi_0110"});
    vecs.push_back('{4'b1010, 2'd3, 1'b1, "multi_1010"});
    vecs.push_back('{4'b1111, 2'd3, 1'b1, "multi_1111"});
    // zero transitions
    vecs.push_back('{4'b0000, 2'd0, 1'b0, "zero_a"});
    vecs.push_back('{4'b0001, 2'd0, 1'b1, "rise_0001"});
    vecs.push_back('{4'b0110, 2'd2, 1'b1, "set_0110"});
    vecs.push_back('{4'b0000, 2'd0, 1'b0, "fall_0000"});

    rst_n = 1'b0;
    b4.in = 4'b1111;
    b8.in = '0;
    b5.in = '0;

    // reset holds outputs clear even across edges
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", b4.out, 0);
    chk("rst_valid", b4.valid, 0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_out", b4.out, 3);
    chk("rel_valid", b4.valid, 1);

    // asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out", b4.out, 0);
    chk("async_valid", b4.valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b4.in = 4'b0000;
    tick();
    chk("post_rst_zero", b4.valid, 0);

    // table vectors
    foreach (vecs[k]) begin
      @(negedge clk);
      b4.in = vecs[k].in;
      tick();
      chk({vecs[k].name, "_out"}, b4.out, vecs[k].out);
      chk({vecs[k].name, "_valid"}, b4.valid, vecs[k].valid);
    end

    // valid must not drop before the edge following in -> 0
    @(negedge clk);
    b4.in = 4'b0110;
    tick();
    @(negedge clk);
    b4.in = 4'b0000;
    #1;
    chk("fall_hold_valid", b4.valid, 1);
    chk("fall_hold_out", b4.out, 2);
    tick();
    chk("fall_valid", b4.valid, 0);
    chk("fall_out", b4.out, 0);

    // stability: in=0100 held four cycles, sampled twice per cycle
    @(negedge clk);
    b4.in = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("stable_out", b4.out, 2);
      chk("stable_valid", b4.valid, 1);
      @(negedge clk);
      chk("stable_mid_out", b4.out, 2);
    end

    // WIDTH=8 directed
    b8.in = 8'b0010_1001;
    tick();
    chk("w8_out", b8.out, 5);
    chk("w8_valid", b8.valid, 1);
`ifdef PRIORITY_ENC_ONEHOT_EN
    chk("w8_onehot", b8.out_onehot, 64'h20);
`endif
    @(negedge clk);
    b8.in = 8'h00;
    tick();
    chk("w8_zero_valid", b8.valid, 0);
    chk("w8_zero_out", b8.out, 0);
`ifdef PRIORITY_ENC_ONEHOT_EN
    chk("w8_zero_onehot", b8.out_onehot, 0);
`endif
    @(negedge clk);
    b8.in = 8'h80;
    b5.in = 5'b10000;
    tick();
    chk("w8_msb", b8.out, 7);
    chk("w5_msb", b5.out, 4);

    // randomized against the reference model
    for (int n = 0; n < 400; n++) begin
      logic [3:0] r4;
      logic [7:0] r8;
      logic [4:0] r5;
      @(negedge clk);
      r4 = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      r8 = ($urandom_range(0, 3) == 0) ? 8'h0 : 8'($urandom);
      r5 = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom);
      if ($urandom_range(0, 2) == 0) r8 = 8'($urandom_range(0, 7));
      b4.in = r4;
      b8.in = r8;
      b5.in = r5;
      tick();
      chk("rnd4_out", b4.out, top_bit(64'(r4)));
      chk("rnd4_valid", b4.valid, r4 != 0);
      chk("rnd8_out", b8.out, top_bit(64'(r8)));
      chk("rnd8_valid", b8.valid, r8 != 0);
      chk("rnd5_out", b5.out, top_bit(64'(r5)));
      chk("rnd5_valid", b5.valid, r5 != 0);
`ifdef PRIORITY_ENC_ONEHOT_EN
      chk("rnd8_onehot", b8.out_onehot,
          (r8 != 0) ? (64'd1 << top_bit(64'(r8))) : 64'd0);
`endif
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/priority_enc.md
Name: priority_enc

Overview:
- Parameterised, registered priority encoder.
- Each cycle it reports the index of the highest-numbered asserted request bit (MSB has highest priority), plus a valid flag.
- Outputs are registered, so a request vector yields its result one clock later.
- Sits between request sources and any consumer that needs a compact winner index, e.g. interrupt or arbitration front ends.

Parameters:
- WIDTH, 4: number of request bits; legal range 2..64.
- OUT_W, $clog2(WIDTH): width of the index output; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  request vector; bit WIDTH-1 has highest priority.
- out  output  OUT_W  registered index of the highest set bit of in.
- valid  output  1  registered; 1 when any bit of in was set.
- out_onehot  output  WIDTH  registered one-hot grant; present only with PRIORITY_ENC_ONEHOT_EN.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: rst_n low immediately forces out=0, valid=0 and out_onehot=0, regardless of clk. Release is synchronised by the consumer.
- Combinational stage:
  - idx = largest i with in[i]==1; v = |in.
  - in==0 gives idx=0, v=0.
- Register stage, on each posedge clk with rst_n high: out<=idx, valid<=v.
- Latency: exactly 1 cycle from in to out/valid. No handshake; a new result is produced every cycle.
- Zero input: valid=0 and out=0. out is never left holding a stale index.
- Multiple bits set: lower bits are ignored. Examples for WIDTH=4:
  - in=4'b1100 -> out=3.
  - in=4'b0110 -> out=2.
  - in=4'b1010 -> out=3.
- Single-hot input: out equals the bit position, e.g. 4'b0001->0, 4'b0010->1, 4'b0100->2, 4'b1000->3.
- in[WIDTH-1]==1 always gives out=WIDTH-1.
- Range: out is always < WIDTH; when valid==1, out indexes a bit that was set.
- Stability:
  - If in is stable for N cycles, out and valid are stable from the second of those cycles onward.
  - Outputs change only in the cycle after in changes, and only if the encoded result differs.
- Transitions:
  - in goes 0 -> nonzero: valid rises one cycle later.
  - in goes nonzero -> 0: valid falls one cycle later.
  - valid stays high while in stays nonzero.
- Reset mid-operation: outputs clear immediately. The first post-reset edge samples the current in.
- Non-power-of-two WIDTH: out uses OUT_W bits; unused codes are never produced.
- No X propagation: in containing X/Z is illegal. The bench flags it; RTL need not handle it.

Optional Feature:
- Macro PRIORITY_ENC_ONEHOT_EN.
- Defined:
  - Adds the out_onehot port, registered with the same latency as out.
  - out_onehot has exactly the bit at idx set when v==1, and is all-zero when in==0.
  - Invariant: out_onehot == (valid << out) whenever valid==1.
- Undefined: the port and its logic are absent; out and valid behaviour is unchanged.

Decomposition:
- Package priority_enc_pkg holds:
  - the default width constant (4);
  - a function clog2_min1 (returns at least 1, so WIDTH=2 gives OUT_W=1);
  - a typedef for the result struct {logic valid; logic [OUT_W-1:0] idx} built at the default width.
- Sub-module priority_enc_ffs: purely combinational find-first-set from MSB.
  - Parameter WIDTH; outputs idx, v and onehot.
  - Implemented as a log2-depth tree of 2:1 priority merges, not a linear loop, to keep timing flat at WIDTH=64.
- The top level instantiates priority_enc_ffs and adds the register stage, the reset and the macro-gated one-hot register.

Test Plan:
- Reset: hold rst_n=0 with in=4'b1111 -> out=0, valid=0. Release and apply one edge -> out=3, valid=1. Assert rst_n low between edges -> outputs clear immediately.
- Single-hot sweep: in=0001,0010,0100,1000, 20 ns each -> one cycle after each step, out=0,1,2,3 with valid=1.
- Multi-hot priority: in=1100, 0110, 1010, 1111 -> out=3, 2, 3, 3 one cycle later, valid=1.
- Zero transitions:
  - in 0000->0001 -> valid 0 then 1 on the next edge, out=0.
  - in 0110->0000 -> valid falls next edge, out=0.
- Stability: hold in=0100 for 4 cycles -> out=2 and valid=1 constant from cycle 2 onward; no glitch on any edge.
- WIDTH=8 with PRIORITY_ENC_ONEHOT_EN defined: in=8'b0010_1001 -> out=5, valid=1, out_onehot=8'b0010_0000. in=0 -> out_onehot=0.
